// File: rtl/mpc_pkg.sv
// Shared constants and types for the mpc configuration controller.
// Register map offsets, FSM state encoding and the configuration width used by mpc.
package mpc_pkg;

    localparam int CFG_W = 4;

    localparam logic [7:0] CTRL_OFS   = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;
    localparam logic [7:0] HOLD_OFS   = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_SWAP,
        ST_SETTLE
    } cfg_state_e;

endpackage

// File: rtl/mpc_wb_regs.sv
// Wishbone slave for the config controller: window decode, ack, CTRL/STATUS/HOLD registers.
// Latency: registered ack one cycle after a hit; writes commit on the ack-setting edge.
// Backpressure: none; a hit is always acked, a decode miss is never acked.
module mpc_wb_regs
    import mpc_pkg::*;
#(
    parameter logic [31:0]      BASE_ADR     = 32'h3000_0000,
    parameter logic [CFG_W-1:0] RESET_CFG    = '0,
    parameter logic [7:0]       DEFAULT_HOLD = 8'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [CFG_W-1:0] configuration,
    input  logic             busy,
    input  logic [7:0]       switch_cnt,
    input  logic             pending_clr,
    output logic [CFG_W-1:0] req,
    output logic             pending,
    output logic [7:0]       hold
);

    logic        hit;
    logic        access;
    logic [7:0]  ofs;
    logic [31:0] rd_dat;
    logic        wb_unused;

    assign hit       = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign access    = hit && !wbs_ack_o;
    assign ofs       = {wbs_adr_i[7:2], 2'b00};
    assign wb_unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    always_comb begin
        rd_dat = '0;
        case (ofs)
            CTRL_OFS:   rd_dat = {28'd0, req};
            STATUS_OFS: rd_dat = {16'd0, switch_cnt, 2'b00, pending, busy, configuration};
            HOLD_OFS:   rd_dat = {24'd0, hold};
            default:    rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            req       <= RESET_CFG;
            pending   <= 1'b0;
            hold      <= DEFAULT_HOLD;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= access ? rd_dat : '0;
            // A fresh CTRL write beats the FSM's consume so the newest request is never lost.
            if (access && wbs_we_i && wbs_sel_i[0] && ofs == CTRL_OFS) begin
                req     <= wbs_dat_i[CFG_W-1:0];
                pending <= 1'b1;
            end else if (pending_clr) begin
                pending <= 1'b0;
            end
            if (access && wbs_we_i && wbs_sel_i[0] && ofs == HOLD_OFS) begin
                hold <= wbs_dat_i[7:0];
            end
        end
    end

endmodule

// File: rtl/mpc_cfg_ctrl.sv
// Sequences configuration changes for mpc: hold IO, quiesce, swap, settle, release.
// Latency: io_hold rises one cycle after the CTRL commit; a switch holds IO for 2*HOLD+3 cycles.
// Backpressure: none; requests arriving mid-sequence coalesce into one follow-up switch.
module mpc_cfg_ctrl
    import mpc_pkg::*;
#(
    parameter logic [31:0]      BASE_ADR     = 32'h3000_0000,
    parameter logic [CFG_W-1:0] RESET_CFG    = '0,
    parameter logic [7:0]       DEFAULT_HOLD = 8'd4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [CFG_W-1:0] configuration,
    output logic             io_hold,
    output logic             cfg_busy
);

    cfg_state_e       state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [7:0]       switch_cnt, switch_cnt_nxt;
    logic [CFG_W-1:0] tgt, tgt_nxt;
    logic [CFG_W-1:0] cfg_nxt;
    logic [CFG_W-1:0] req;
    logic             pending;
    logic             pending_clr;
    logic [7:0]       hold;

    mpc_wb_regs #(
        .BASE_ADR     (BASE_ADR),
        .RESET_CFG    (RESET_CFG),
        .DEFAULT_HOLD (DEFAULT_HOLD)
    ) u_regs (
        .clk           (wb_clk_i),
        .rst_n         (wb_rst_ni),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .configuration (configuration),
        .busy          (cfg_busy),
        .switch_cnt    (switch_cnt),
        .pending_clr   (pending_clr),
        .req           (req),
        .pending       (pending),
        .hold          (hold)
    );

    // Decoded from the async-reset state register so the hold drops the instant reset asserts.
    assign io_hold  = (state != ST_IDLE);
    assign cfg_busy = io_hold;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            switch_cnt    <= '0;
            tgt           <= RESET_CFG;
            configuration <= RESET_CFG;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            switch_cnt    <= switch_cnt_nxt;
            tgt           <= tgt_nxt;
            configuration <= cfg_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        switch_cnt_nxt = switch_cnt;
        tgt_nxt        = tgt;
        cfg_nxt        = configuration;
        pending_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    pending_clr = 1'b1;
                    if (req != configuration) begin
                        state_nxt = ST_QUIESCE;
                        tgt_nxt   = req;
                        cnt_nxt   = hold;
                    end
                end
            end
            ST_QUIESCE: begin
                if (cnt == 8'd0) state_nxt = ST_SWAP;
                else             cnt_nxt   = cnt - 8'd1;
            end
            ST_SWAP: begin
                cfg_nxt   = tgt;
                cnt_nxt   = hold;
                state_nxt = ST_SETTLE;
                if (switch_cnt != 8'hFF) switch_cnt_nxt = switch_cnt + 8'd1;
            end
            ST_SETTLE: begin
                if (cnt == 8'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
